// File: rtl/core_mem_unit.sv
// Instruction/data memory for the core: separate IRAM and DRAM with a fixed-latency
// in-order read pipeline per channel, a preload port, saturating access counters and a sticky range error.
module core_mem_unit #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int DEPTH_LOG2 = 8,
    parameter int READ_LAT   = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     pc_in,
    input  logic [ADDR_W-1:0]     ar_in,
    input  logic [DATA_W-1:0]     wdata_in,
    input  logic [1:0]            read_en,
    input  logic                  write_en,
    input  logic                  load_en,
    input  logic                  load_sel,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [DATA_W-1:0]     load_data,
    output logic [DATA_W-1:0]     iram_out,
    output logic                  iram_valid,
    output logic [DATA_W-1:0]     dram_out,
    output logic                  dram_valid,
    output logic                  addr_err,
    output logic [CNT_W-1:0]      fetch_cnt,
    output logic [CNT_W-1:0]      rd_cnt,
    output logic [CNT_W-1:0]      wr_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_W-1:0]     iram_mem_r [DEPTH];
    logic [DATA_W-1:0]     dram_mem_r [DEPTH];
    logic [DATA_W-1:0]     i_data_r   [READ_LAT];
    logic [DATA_W-1:0]     d_data_r   [READ_LAT];
    logic [READ_LAT-1:0]   i_vld_r;
    logic [READ_LAT-1:0]   d_vld_r;
    logic [CNT_W-1:0]      fetch_cnt_r;
    logic [CNT_W-1:0]      rd_cnt_r;
    logic [CNT_W-1:0]      wr_cnt_r;
    logic                  addr_err_r;
    logic [DEPTH_LOG2-1:0] pc_idx_s;
    logic [DEPTH_LOG2-1:0] ar_idx_s;
    logic                  pc_oor_s;
    logic                  ar_oor_s;
    logic                  err_hit_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign pc_idx_s  = pc_in[DEPTH_LOG2-1:0];
    assign ar_idx_s  = ar_in[DEPTH_LOG2-1:0];
    assign pc_oor_s  = (pc_in >> DEPTH_LOG2) != {ADDR_W{1'b0}};
    assign ar_oor_s  = (ar_in >> DEPTH_LOG2) != {ADDR_W{1'b0}};
    assign err_hit_s = (read_en[0] & pc_oor_s) | ((read_en[1] | write_en) & ar_oor_s);

    // Array writes; contents survive reset. Core write is issued last so it wins a same-word preload.
    always_ff @(posedge clock) begin
        if (load_en && !load_sel) begin
            iram_mem_r[load_addr] <= load_data;
        end
        if (load_en && load_sel) begin
            dram_mem_r[load_addr] <= load_data;
        end
        if (write_en) begin
            dram_mem_r[ar_idx_s] <= wdata_in;
        end
    end

    // Read pipelines: stage 0 samples the array (old data on same-edge writes), later stages
    // only advance with a valid token so the last stage holds its value between results.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            i_vld_r <= {READ_LAT{1'b0}};
            d_vld_r <= {READ_LAT{1'b0}};
            for (int i = 0; i < READ_LAT; i++) begin
                i_data_r[i] <= {DATA_W{1'b0}};
                d_data_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            i_vld_r[0] <= read_en[0];
            d_vld_r[0] <= read_en[1];
            if (read_en[0]) begin
                i_data_r[0] <= iram_mem_r[pc_idx_s];
            end
            if (read_en[1]) begin
                d_data_r[0] <= dram_mem_r[ar_idx_s];
            end
            for (int i = 1; i < READ_LAT; i++) begin
                i_vld_r[i] <= i_vld_r[i-1];
                d_vld_r[i] <= d_vld_r[i-1];
                if (i_vld_r[i-1]) begin
                    i_data_r[i] <= i_data_r[i-1];
                end
                if (d_vld_r[i-1]) begin
                    d_data_r[i] <= d_data_r[i-1];
                end
            end
        end
    end

    // Access counters and sticky range error; preload traffic is deliberately not counted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_r <= {CNT_W{1'b0}};
            rd_cnt_r    <= {CNT_W{1'b0}};
            wr_cnt_r    <= {CNT_W{1'b0}};
            addr_err_r  <= 1'b0;
        end else begin
            if (read_en[0]) begin
                fetch_cnt_r <= sat_inc(fetch_cnt_r);
            end
            if (read_en[1]) begin
                rd_cnt_r <= sat_inc(rd_cnt_r);
            end
            if (write_en) begin
                wr_cnt_r <= sat_inc(wr_cnt_r);
            end
            addr_err_r <= addr_err_r | err_hit_s;
        end
    end

    assign iram_out   = i_data_r[READ_LAT-1];
    assign iram_valid = i_vld_r[READ_LAT-1];
    assign dram_out   = d_data_r[READ_LAT-1];
    assign dram_valid = d_vld_r[READ_LAT-1];
    assign addr_err   = addr_err_r;
    assign fetch_cnt  = fetch_cnt_r;
    assign rd_cnt     = rd_cnt_r;
    assign wr_cnt     = wr_cnt_r;

endmodule

// File: tb/tb_core_mem_unit.sv
// Drives three core_mem_unit instances (READ_LAT 1/3/4, the last with 4-bit counters) with shared
// stimulus and compares every cycle against a request-history reference model.
module tb_core_mem_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] pc_in, ar_in, wdata_in, load_data;
    logic [1:0]  read_en;
    logic        write_en, load_en, load_sel;
    logic [7:0]  load_addr;

    logic [15:0] iram_out [3];
    logic [15:0] dram_out [3];
    logic        iram_valid [3];
    logic        dram_valid [3];
    logic        addr_err [3];
    logic [15:0] fetch_cnt [2];
    logic [15:0] rd_cnt [2];
    logic [15:0] wr_cnt [2];
    logic [3:0]  fc_s, rc_s, wc_s;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    core_mem_unit #(.READ_LAT(1)) dut_l1 (
        .clock(clock), .reset_n(reset_n), .pc_in(pc_in), .ar_in(ar_in), .wdata_in(wdata_in),
        .read_en(read_en), .write_en(write_en), .load_en(load_en), .load_sel(load_sel),
        .load_addr(load_addr), .load_data(load_data), .iram_out(iram_out[0]), .iram_valid(iram_valid[0]),
        .dram_out(dram_out[0]), .dram_valid(dram_valid[0]), .addr_err(addr_err[0]),
        .fetch_cnt(fetch_cnt[0]), .rd_cnt(rd_cnt[0]), .wr_cnt(wr_cnt[0]));

    core_mem_unit #(.READ_LAT(3)) dut_l3 (
        .clock(clock), .reset_n(reset_n), .pc_in(pc_in), .ar_in(ar_in), .wdata_in(wdata_in),
        .read_en(read_en), .write_en(write_en), .load_en(load_en), .load_sel(load_sel),
        .load_addr(load_addr), .load_data(load_data), .iram_out(iram_out[1]), .iram_valid(iram_valid[1]),
        .dram_out(dram_out[1]), .dram_valid(dram_valid[1]), .addr_err(addr_err[1]),
        .fetch_cnt(fetch_cnt[1]), .rd_cnt(rd_cnt[1]), .wr_cnt(wr_cnt[1]));

    core_mem_unit #(.READ_LAT(4), .CNT_W(4)) dut_l4 (
        .clock(clock), .reset_n(reset_n), .pc_in(pc_in), .ar_in(ar_in), .wdata_in(wdata_in),
        .read_en(read_en), .write_en(write_en), .load_en(load_en), .load_sel(load_sel),
        .load_addr(load_addr), .load_data(load_data), .iram_out(iram_out[2]), .iram_valid(iram_valid[2]),
        .dram_out(dram_out[2]), .dram_valid(dram_valid[2]), .addr_err(addr_err[2]),
        .fetch_cnt(fc_s), .rd_cnt(rc_s), .wr_cnt(wc_s));

    // Reference model: memory images plus a per-edge history of requests and the data they saw.
    logic [15:0] m_iram [256];
    logic [15:0] m_dram [256];
    logic        h_iv [4096];
    logic        h_dv [4096];
    logic [15:0] h_id [4096];
    logic [15:0] h_dd [4096];
    logic        e_iv [3];
    logic        e_dv [3];
    logic [15:0] e_io [3];
    logic [15:0] e_do [3];
    int          cyc = 0;
    int          first_ok = 1;
    int          n_f, n_r, n_w;
    logic        m_err;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int satv(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t", tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic model_flush();
        first_ok = cyc + 1;
        n_f = 0; n_r = 0; n_w = 0;
        m_err = 1'b0;
        for (int k = 0; k < 3; k++) begin
            e_iv[k] = 1'b0; e_dv[k] = 1'b0; e_io[k] = 16'd0; e_do[k] = 16'd0;
        end
    endtask

    task automatic model_edge();
        int idx;
        cyc++;
        h_iv[cyc] = read_en[0];
        h_dv[cyc] = read_en[1];
        h_id[cyc] = m_iram[pc_in[7:0]];
        h_dd[cyc] = m_dram[ar_in[7:0]];
        for (int k = 0; k < 3; k++) begin
            idx = cyc - (lat_of(k) - 1);
            e_iv[k] = (idx >= first_ok) && h_iv[idx];
            e_dv[k] = (idx >= first_ok) && h_dv[idx];
            if (e_iv[k]) e_io[k] = h_id[idx];
            if (e_dv[k]) e_do[k] = h_dd[idx];
        end
        if (load_en && !load_sel) m_iram[load_addr] = load_data;
        if (load_en && load_sel)  m_dram[load_addr] = load_data;
        if (write_en)             m_dram[ar_in[7:0]] = wdata_in;
        if (read_en[0]) n_f++;
        if (read_en[1]) n_r++;
        if (write_en)   n_w++;
        if ((read_en[0] && pc_in[15:8] != 8'd0) ||
            ((read_en[1] || write_en) && ar_in[15:8] != 8'd0)) m_err = 1'b1;
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("iram_valid[L%0d]", lat_of(k)), 32'(iram_valid[k]), 32'(e_iv[k]));
            check_eq($sformatf("iram_out[L%0d]", lat_of(k)),   32'(iram_out[k]),   32'(e_io[k]));
            check_eq($sformatf("dram_valid[L%0d]", lat_of(k)), 32'(dram_valid[k]), 32'(e_dv[k]));
            check_eq($sformatf("dram_out[L%0d]", lat_of(k)),   32'(dram_out[k]),   32'(e_do[k]));
            check_eq($sformatf("addr_err[L%0d]", lat_of(k)),   32'(addr_err[k]),   32'(m_err));
        end
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("fetch_cnt[%0d]", k), 32'(fetch_cnt[k]), 32'(satv(n_f, 65535)));
            check_eq($sformatf("rd_cnt[%0d]", k),    32'(rd_cnt[k]),    32'(satv(n_r, 65535)));
            check_eq($sformatf("wr_cnt[%0d]", k),    32'(wr_cnt[k]),    32'(satv(n_w, 65535)));
        end
        check_eq("fetch_cnt4", 32'(fc_s), 32'(satv(n_f, 15)));
        check_eq("rd_cnt4",    32'(rc_s), 32'(satv(n_r, 15)));
        check_eq("wr_cnt4",    32'(wc_s), 32'(satv(n_w, 15)));
    endtask

    task automatic idle();
        read_en = 2'b00; write_en = 1'b0; load_en = 1'b0; load_sel = 1'b0;
        pc_in = 16'd0; ar_in = 16'd0; wdata_in = 16'd0; load_addr = 8'd0; load_data = 16'd0;
    endtask

    task automatic step();
        @(posedge clock);
        if (reset_n) model_edge();
        #1;
        check_all();
    endtask

    task automatic preload(input logic sel, input logic [7:0] a, input logic [15:0] d);
        idle(); load_en = 1'b1; load_sel = sel; load_addr = a; load_data = d;
        step();
    endtask

    logic [15:0] tp_fetch [4];

    initial begin
        tp_fetch[0] = 16'd1025; tp_fetch[1] = 16'd2050; tp_fetch[2] = 16'd5120; tp_fetch[3] = 16'd3072;
        idle();
        reset_n = 1'b0;
        model_flush();
        #22;
        check_all();
        reset_n = 1'b1;

        for (int i = 0; i < 256; i++) begin
            preload(1'b0, 8'(i), 16'($urandom));
            preload(1'b1, 8'(i), 16'($urandom));
        end
        for (int i = 0; i < 4; i++) preload(1'b0, 8'(i), tp_fetch[i]);
        preload(1'b1, 8'd1, 16'd3);
        preload(1'b1, 8'd2, 16'd2);
        preload(1'b1, 8'd5, 16'h0011);

        // Back-to-back fetches with next-cycle data on the L1 instance
        for (int i = 0; i < 4; i++) begin
            idle(); read_en = 2'b01; pc_in = 16'(i);
            step();
            check_eq("tp1_iram_out", 32'(iram_out[0]), 32'(tp_fetch[i]));
            check_eq("tp1_iram_valid", 32'(iram_valid[0]), 32'd1);
        end
        idle();
        repeat (4) step();
        check_eq("tp1_fetch_cnt", 32'(fetch_cnt[0]), 32'd4);

        // Two reads through the L3 instance
        idle(); read_en = 2'b10; ar_in = 16'd1; step();
        idle(); read_en = 2'b10; ar_in = 16'd2; step();
        idle(); step();
        check_eq("tp2_first", 32'(dram_out[1]), 32'd3);
        check_eq("tp2_first_valid", 32'(dram_valid[1]), 32'd1);
        step();
        check_eq("tp2_second", 32'(dram_out[1]), 32'd2);
        step();
        check_eq("tp2_rd_cnt", 32'(rd_cnt[1]), 32'd2);

        // Read-before-write on the same word
        idle(); read_en = 2'b10; write_en = 1'b1; ar_in = 16'd5; wdata_in = 16'h00AB; step();
        check_eq("tp3_old_data", 32'(dram_out[0]), 32'h0011);
        idle(); read_en = 2'b10; ar_in = 16'd5; step();
        check_eq("tp3_new_data", 32'(dram_out[0]), 32'h00AB);
        check_eq("tp3_wr_cnt", 32'(wr_cnt[0]), 32'd1);

        // Out-of-range fetch wraps and sets the sticky error
        idle(); read_en = 2'b01; pc_in = 16'h0100; step();
        check_eq("tp4_wrap", 32'(iram_out[0]), 32'd1025);
        check_eq("tp4_err", 32'(addr_err[0]), 32'd1);
        idle(); read_en = 2'b01; pc_in = 16'd1; step();
        check_eq("tp4_err_sticky", 32'(addr_err[0]), 32'd1);

        // Preload collisions: fetch sees old IRAM word, core write beats DRAM preload
        idle(); read_en = 2'b01; pc_in = 16'd2; load_en = 1'b1; load_addr = 8'd2; load_data = 16'h7777; step();
        check_eq("pl_fetch_old", 32'(iram_out[0]), 32'd5120);
        idle(); read_en = 2'b01; pc_in = 16'd2; step();
        check_eq("pl_fetch_new", 32'(iram_out[0]), 32'h7777);
        idle(); write_en = 1'b1; ar_in = 16'd9; wdata_in = 16'h2222;
        load_en = 1'b1; load_sel = 1'b1; load_addr = 8'd9; load_data = 16'h1111; step();
        idle(); write_en = 1'b1; ar_in = 16'd11; wdata_in = 16'h4444;
        load_en = 1'b1; load_sel = 1'b1; load_addr = 8'd10; load_data = 16'h3333; step();
        idle(); read_en = 2'b10; ar_in = 16'd9; step();
        check_eq("pl_core_wins", 32'(dram_out[0]), 32'h2222);
        idle(); read_en = 2'b10; ar_in = 16'd10; step();
        check_eq("pl_both_a", 32'(dram_out[0]), 32'h3333);
        idle(); read_en = 2'b10; ar_in = 16'd11; step();
        check_eq("pl_both_b", 32'(dram_out[0]), 32'h4444);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            idle();
            read_en   = 2'($urandom);
            write_en  = ($urandom_range(0, 3) == 0);
            load_en   = ($urandom_range(0, 4) == 0);
            load_sel  = 1'($urandom);
            load_addr = 8'($urandom);
            load_data = 16'($urandom);
            wdata_in  = 16'($urandom);
            pc_in     = ($urandom_range(0, 31) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
            ar_in     = ($urandom_range(0, 31) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
            step();
        end
        idle();
        repeat (5) step();

        // Reset with two reads in flight on the L4 instance
        idle(); read_en = 2'b10; ar_in = 16'd1; step();
        idle(); read_en = 2'b10; ar_in = 16'd2; step();
        idle();
        reset_n = 1'b0;
        #1;
        model_flush();
        check_all();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("rst_no_valid", 32'(dram_valid[2]), 32'd0);
        end
        check_eq("rst_dram_out", 32'(dram_out[2]), 32'd0);
        check_eq("rst_rd_cnt", 32'(rc_s), 32'd0);
        idle(); read_en = 2'b10; ar_in = 16'd1; step();
        idle();
        repeat (4) step();

        // Saturation of the 4-bit fetch counter
        for (int i = 0; i < 20; i++) begin
            idle(); read_en = 2'b01; pc_in = 16'($urandom_range(0, 255)); step();
        end
        idle();
        repeat (4) step();
        check_eq("sat_fetch_cnt4", 32'(fc_s), 32'd15);
        check_eq("sat_fetch_cnt16", 32'(fetch_cnt[0]), 32'd20);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/core_mem_unit.md
Name: core_mem_unit

Overview:
- Parametrised, synthesisable instruction/data memory that replaces hand-driven iram_in/dram_in stimulus for the core.
- Holds separate instruction (IRAM) and data (DRAM) arrays. Serves core fetches from pc_out and data reads/writes at ar_out through a configurable-latency read pipeline.
- Provides a preload port for programs and data, plus saturating access counters and an address-range error flag for bring-up.

Parameters:
DATA_W, 16, word width of both arrays and all data ports
ADDR_W, 16, width of core address buses (pc_out, ar_out)
DEPTH_LOG2, 8, log2 of words per array (IRAM and DRAM each 2^DEPTH_LOG2)
READ_LAT, 1, read latency in cycles, legal 1..4
CNT_W, 16, width of each access counter

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
pc_in  in  ADDR_W  instruction fetch address (core pc_out)
ar_in  in  ADDR_W  data address (core ar_out)
wdata_in  in  DATA_W  data to write (core dram_out)
read_en  in  2  bit0 = instruction fetch request, bit1 = data read request
write_en  in  1  data write request to DRAM at ar_in
load_en  in  1  preload strobe
load_sel  in  1  0 = IRAM, 1 = DRAM
load_addr  in  DEPTH_LOG2  preload word address
load_data  in  DATA_W  preload word
iram_out  out  DATA_W  fetched instruction (to core iram_in)
iram_valid  out  1  one-cycle pulse, iram_out holds new fetch result
dram_out  out  DATA_W  read data (to core dram_in)
dram_valid  out  1  one-cycle pulse, dram_out holds new read result
addr_err  out  1  sticky: any accepted access had nonzero address bits above DEPTH_LOG2
fetch_cnt  out  CNT_W  accepted instruction fetches, saturating
rd_cnt  out  CNT_W  accepted data reads, saturating
wr_cnt  out  CNT_W  accepted data writes (core only, not preload), saturating

Behaviour:
- Reset (reset_n low, async):
  - iram_out, dram_out, all counters = 0; iram_valid, dram_valid, addr_err = 0.
  - Read pipelines are flushed; in-flight reads are dropped and never produce a valid pulse.
  - Array contents are not cleared.
- Addressing: arrays are indexed by address[DEPTH_LOG2-1:0]. Upper bits are ignored (wrap). A nonzero upper bit on any accepted fetch, read or write sets addr_err until reset.
- Fetch: read_en[0] high at edge N samples IRAM[pc_in]. iram_out updates and iram_valid pulses at edge N+READ_LAT-1, i.e. visible in cycle N+READ_LAT; READ_LAT=1 gives next-cycle data.
- Data read: same timing on read_en[1] with DRAM[ar_in], dram_out and dram_valid.
- Fully pipelined: a new request is accepted every cycle on each channel; results return in order.
- Between results, iram_out and dram_out hold their last value; valid is low.
- Write: write_en high at edge N writes DRAM[ar_in] = wdata_in at edge N.
- Write and read to the same DRAM word in the same cycle: the read returns the old data (read-before-write).
- write_en and read_en[1] to different words in the same cycle: both proceed.
- Preload: load_en high writes load_data into the array chosen by load_sel at that edge.
  - Preload to DRAM in the same cycle as a core write_en: the core write wins if the word indices match, otherwise both proceed.
  - Preload to IRAM in the same cycle as a fetch of the same word: the fetch returns the old data.
  - Preload does not affect counters or addr_err.
- Counters: increment by 1 per accepted request and hold at all-ones (saturate, no wrap).
- No backpressure; the core must tolerate fixed READ_LAT.

Test Plan:
- Preload IRAM[0..3] = 1025, 2050, 5120, 3072; READ_LAT=1; fetch pc 0..3 back-to-back -> iram_out 1025, 2050, 5120, 3072 on consecutive cycles, iram_valid high for 4 cycles, fetch_cnt = 4.
- READ_LAT=3; preload DRAM[1] = 3, DRAM[2] = 2; read ar 1 then 2 -> dram_out 3 then 2 exactly 3 cycles after each request, in order, rd_cnt = 2.
- Write ar 5 data 0x00AB with a simultaneous read of ar 5 -> that read returns the old value. A read of ar 5 in the next cycle returns 0x00AB; wr_cnt = 1.
- Fetch pc 0x0100 with DEPTH_LOG2=8 -> returns IRAM[0] and addr_err = 1. A subsequent in-range fetch keeps addr_err = 1.
- READ_LAT=4; issue 2 reads, assert reset_n low for 1 cycle after 2 cycles -> no dram_valid pulse afterward; dram_out = 0 and counters = 0 after reset; DRAM contents are preserved on a re-read.
- CNT_W=4; issue 20 fetches -> fetch_cnt stops at 15.
